// File: rtl/keypad_scanner_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its consumers.
// Key codes are row*4+col, which is simply the {row, col} bit concatenation.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } scan_state_t;

  typedef enum logic [1:0] {
    FRAME_EMPTY,
    FRAME_SINGLE,
    FRAME_MULTI
  } frame_kind_t;

  // Code 0 is a real key, so KEY_NONE is only meaningful alongside frame_kind_t.
  localparam logic [3:0] KEY_NONE       = 4'h0;
  localparam logic [3:0] KEY_START_STOP = 4'hA;
  localparam logic [3:0] KEY_RESET      = 4'hB;
  localparam logic [3:0] KEY_LAP        = 4'hC;

  function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad-side signals plus the debounced key event outputs of the scanner.
interface keypad_scanner_if;

  logic [3:0] row_in;
  logic [3:0] col_out;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_held;

  modport slave (
    input  row_in,
    output col_out,
    output key_valid,
    output key_code,
    output key_held
  );

  modport master (
    output row_in,
    input  col_out,
    input  key_valid,
    input  key_code,
    input  key_held
  );

endinterface

// File: rtl/keypad_scanner_scan_tick_gen.sv
// Divides the system clock down to a one-clk tick at SCAN_HZ; shared with the display refresh.
module scan_tick_gen #(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned DIV  = CLK_HZ / SCAN_HZ;
  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one active-low column per scan tick, per-frame
// classification of the rows, and a debounce FSM that emits one code per press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 100_000_000,
  parameter int unsigned SCAN_HZ         = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 8
) (
  input  logic              clk,
  input  logic              reset,
  keypad_scanner_if.slave   kp
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] DB_MAX = CNT_W'(DEBOUNCE_FRAMES);

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic             scan_tick;
  logic [1:0]       col_idx;
  logic [3:0]       col_drive;
  logic [1:0]       hit_cnt;
  logic [3:0]       hit_code;
  logic [3:0]       row_hit;
  logic [1:0]       sample_row;
  logic [2:0]       sample_n;
  logic [2:0]       frame_sum;
  logic [3:0]       merged_code;
  logic             frame_end;
  frame_kind_t      frame_kind;
  scan_state_t      state;
  scan_state_t      state_next;
  logic [3:0]       cand;
  logic [3:0]       cand_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       code_reg;
  logic [3:0]       code_next;
  logic             held_reg;
  logic             held_next;
  logic             valid_reg;
  logic             valid_next;

  // Rows idle high through the pull-ups, so the synchronizer resets to all ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= kp.row_in;
      row_sync <= row_meta;
    end
  end

  scan_tick_gen #(
    .CLK_HZ  (CLK_HZ),
    .SCAN_HZ (SCAN_HZ)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .tick  (scan_tick)
  );

  // Column drive is registered directly so the pins never glitch on an index change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_idx   <= 2'd0;
      col_drive <= 4'b1110;
    end else if (scan_tick) begin
      col_idx   <= col_idx + 2'd1;
      col_drive <= {col_drive[2:0], col_drive[3]};
    end
  end

  assign kp.col_out = col_drive;
  assign row_hit    = ~row_sync;
  assign frame_end  = scan_tick && (col_idx == 2'd3);

  always_comb begin
    sample_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (row_hit[r]) sample_row = 2'(r);
    end
    sample_n    = 3'(row_hit[0]) + 3'(row_hit[1]) + 3'(row_hit[2]) + 3'(row_hit[3]);
    frame_sum   = 3'(hit_cnt) + sample_n;
    merged_code = (hit_cnt != 2'd0) ? hit_code : key_index(sample_row, col_idx);
    if (frame_sum == 3'd0)      frame_kind = FRAME_EMPTY;
    else if (frame_sum == 3'd1) frame_kind = FRAME_SINGLE;
    else                        frame_kind = FRAME_MULTI;
  end

  // Hit count saturates at 2: anything beyond one pressed key is simply "multi".
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt  <= 2'd0;
      hit_code <= KEY_NONE;
    end else if (scan_tick) begin
      if (col_idx == 2'd3) begin
        hit_cnt  <= 2'd0;
        hit_code <= KEY_NONE;
      end else begin
        hit_cnt  <= (frame_sum >= 3'd2) ? 2'd2 : frame_sum[1:0];
        hit_code <= merged_code;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cand      <= KEY_NONE;
      cnt       <= '0;
      code_reg  <= 4'h0;
      held_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      state     <= state_next;
      cand      <= cand_next;
      cnt       <= cnt_next;
      code_reg  <= code_next;
      held_reg  <= held_next;
      valid_reg <= valid_next;
    end
  end

  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    code_next  = code_reg;
    held_next  = held_reg;
    valid_next = 1'b0;
    cnt_inc    = (cnt >= DB_MAX) ? cnt : cnt + CNT_W'(1);
    if (frame_end) begin
      unique case (state)
        IDLE: begin
          if (frame_kind == FRAME_SINGLE) begin
            cand_next  = merged_code;
            cnt_next   = CNT_W'(1);
            state_next = PRESS_DB;
          end
        end
        PRESS_DB: begin
          if (frame_kind == FRAME_SINGLE && merged_code == cand) begin
            if (cnt_inc >= DB_MAX) begin
              state_next = HELD;
              cnt_next   = '0;
              code_next  = cand;
              held_next  = 1'b1;
              valid_next = 1'b1;
            end else begin
              cnt_next = cnt_inc;
            end
          end else if (frame_kind == FRAME_SINGLE) begin
            cand_next = merged_code;
            cnt_next  = CNT_W'(1);
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
        HELD: begin
          if (frame_kind == FRAME_EMPTY) begin
            cnt_next   = CNT_W'(1);
            state_next = REL_DB;
          end
        end
        REL_DB: begin
          if (frame_kind == FRAME_EMPTY) begin
            if (cnt_inc >= DB_MAX) begin
              state_next = IDLE;
              cnt_next   = '0;
              held_next  = 1'b0;
            end else begin
              cnt_next = cnt_inc;
            end
          end else begin
            state_next = HELD;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  assign kp.key_valid = valid_reg;
  assign kp.key_code  = code_reg;
  assign kp.key_held  = held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench: a behavioural 4x4 keypad drives the rows, a scoreboard queue
// holds the key codes each press should eventually report.
module tb_keypad_scanner;

  localparam int FRAME = 40;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] keys = '0;
  logic [3:0]  exp_q[$];
  logic [3:0]  exp_code;
  logic        prev_valid = 1'b0;
  logic        sync_ok;
  int          checks = 0;
  int          failures = 0;

  keypad_scanner_if kif ();

  keypad_scanner #(
    .CLK_HZ          (1000),
    .SCAN_HZ         (100),
    .DEBOUNCE_FRAMES (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kif.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] row_model(input logic [15:0] k, input logic [3:0] col);
    logic [3:0] rows;
    rows = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (k[r*4+c] && !col[c]) rows[r] = 1'b0;
      end
    end
    return rows;
  endfunction

  assign kif.row_in = row_model(keys, kif.col_out);

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_frame_start(output logic ok);
    int n;
    n = 0;
    while (kif.col_out !== 4'b0111 && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (kif.col_out !== 4'b1110 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (n < 200);
  endtask

  // Every accepted press must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (kif.key_valid === 1'b1) begin
      check("valid_outside_reset", reset, 1);
      check("valid_not_consecutive", prev_valid, 0);
      check("pulse_was_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        exp_code = exp_q.pop_front();
        check("pulse_key_code", kif.key_code, exp_code);
      end
    end
    prev_valid = kif.key_valid;
  end

  initial begin
    wait_clks(3);
    check("reset_col_out", kif.col_out, 4'b1110);
    check("reset_key_valid", kif.key_valid, 0);
    check("reset_key_code", kif.key_code, 0);
    check("reset_key_held", kif.key_held, 0);
    reset = 1'b1;
    wait_clks(9);
    check("col_before_first_tick", kif.col_out, 4'b1110);
    wait_clks(1);
    check("col_after_first_tick", kif.col_out, 4'b1101);

    // Single steady press of key 6, then release.
    keys[6] = 1'b1;
    exp_q.push_back(4'h6);
    wait_clks(5*FRAME);
    check("press6_held", kif.key_held, 1);
    check("press6_code", kif.key_code, 4'h6);
    check("press6_pending", exp_q.size(), 0);
    keys = '0;
    wait_clks(5*FRAME);
    check("release6_held", kif.key_held, 0);
    check("release6_code_kept", kif.key_code, 4'h6);

    // Bouncing contact settles into a single press.
    exp_q.push_back(4'h6);
    for (int i = 0; i < 16; i++) begin
      keys[6] = ~keys[6];
      wait_clks(5);
    end
    keys[6] = 1'b1;
    wait_clks(5*FRAME);
    check("bounce_held", kif.key_held, 1);
    check("bounce_pending", exp_q.size(), 0);
    keys = '0;
    wait_clks(5*FRAME);
    check("bounce_release_held", kif.key_held, 0);

    // Keys 0 and 5 together are a multi-key frame and never accepted.
    keys[0] = 1'b1;
    keys[5] = 1'b1;
    wait_clks(10*FRAME);
    check("multi_held", kif.key_held, 0);
    check("multi_code_kept", kif.key_code, 4'h6);
    keys = '0;
    wait_clks(5*FRAME);
    check("multi_release_held", kif.key_held, 0);

    // Rolling from 6 to 9 without a full release yields no press for 9.
    keys[6] = 1'b1;
    exp_q.push_back(4'h6);
    wait_clks(5*FRAME);
    check("roll_first_code", kif.key_code, 4'h6);
    keys[9] = 1'b1;
    wait_clks(4*FRAME);
    check("roll_both_held", kif.key_held, 1);
    keys[6] = 1'b0;
    wait_clks(5*FRAME);
    check("roll_only9_held", kif.key_held, 1);
    check("roll_only9_code", kif.key_code, 4'h6);
    keys = '0;
    wait_clks(5*FRAME);
    check("roll_release_held", kif.key_held, 0);
    keys[9] = 1'b1;
    exp_q.push_back(4'h9);
    wait_clks(5*FRAME);
    check("repress9_code", kif.key_code, 4'h9);
    check("repress9_held", kif.key_held, 1);
    keys = '0;
    wait_clks(5*FRAME);
    check("repress9_release_held", kif.key_held, 0);

    // Reset while two frames into the press debounce.
    wait_frame_start(sync_ok);
    check("frame_sync", sync_ok, 1);
    keys[6] = 1'b1;
    wait_clks(2*FRAME + 20);
    reset = 1'b0;
    wait_clks(3);
    check("midreset_col_out", kif.col_out, 4'b1110);
    check("midreset_key_code", kif.key_code, 0);
    check("midreset_key_held", kif.key_held, 0);
    check("midreset_key_valid", kif.key_valid, 0);
    reset = 1'b1;
    wait_clks(100);
    check("postreset_no_early_held", kif.key_held, 0);
    check("postreset_no_early_code", kif.key_code, 0);
    exp_q.push_back(4'h6);
    wait_clks(60);
    check("postreset_held", kif.key_held, 1);
    check("postreset_code", kif.key_code, 4'h6);
    keys = '0;
    wait_clks(5*FRAME);
    check("final_pending", exp_q.size(), 0);
    check("final_held", kif.key_held, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
